param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
//
// PURPOSE
//   Parametrised modulo-N up/down counter; next generation of the fixed 2-bit counter.
//   Adds width/modulus parameters, direction control, count enable, sync clear,
//   parallel load, a terminal-count flag and a registered wrap pulse.
//   Used as a building block for dividers, decade counters and timers.
//
// PARAMETERS
//   WIDTH     4   counter width in bits (>=1)
//   MODULUS   10  count range 0..MODULUS-1; legal 2..2**WIDTH
//   RESET_VAL 0   value of q after reset; must be < MODULUS
//
// PORTS
//   clk       in   1      clock; all state updates on the falling (negedge) edge
//   reset     in   1      asynchronous, active-low reset
//   en        in   1      count enable
//   up_dn     in   1      direction: 1 = up, 0 = down
//   clear     in   1      synchronous clear to 0
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value to load
//   q         out  WIDTH  registered count
//   tc        out  1      terminal count, combinational
//   wrap      out  1      registered one-cycle pulse; asserted the cycle after a wrap
//
// BEHAVIOUR
//   - Reset (reset==0, async, overrides everything): q=RESET_VAL, wrap=0. Takes effect at any time, including mid-count.
//   - Per negedge clk, priority: clear > load > en. Idle (none asserted): q holds; wrap=0.
//   - clear:        q=0; wrap=0.
//   - load:         q = (load_val >= MODULUS) ? MODULUS-1 : load_val; wrap=0.
//   - en & up_dn:   q==MODULUS-1 -> q=0, wrap=1. Otherwise q=q+1, wrap=0.
//   - en & !up_dn:  q==0 -> q=MODULUS-1, wrap=1. Otherwise q=q-1, wrap=0.
//   - tc = en & (up_dn ? q==MODULUS-1 : q==0). tc is combinational from the current q, en and up_dn.
//   - wrap is high for exactly one cycle per wrap event; consecutive wraps give consecutive pulses (MODULUS=2 case).
//   - Direction change takes effect on the same edge; no pipeline, count latency 1 edge.
//   - Arithmetic is done in WIDTH+1 bits internally; q never exceeds MODULUS-1.
//   - MODULUS==2**WIDTH: natural binary wrap. The compare logic must still be used, not overflow.
//   - Illegal parameters (MODULUS<2, MODULUS>2**WIDTH, RESET_VAL>=MODULUS) -> $error at elaboration.
//
// CONFIGURATION
//   SATURATE_EN defined:   counter saturates instead of wrapping.
//     - Up at MODULUS-1 holds. Down at 0 holds.
//     - wrap is tied to 0.
//     - tc is unchanged, and stays high while held at the limit with en=1.
//   SATURATE_EN undefined: modulo wrap as described above.
//   Port list is identical in both builds.
//
// TESTING (WIDTH=4, MODULUS=10 unless stated)
//   1. Drive reset low mid-count at q=7 -> q=0 immediately (no clock edge needed), wrap=0.
//      Release, en=1, up_dn=1 -> q=1,2,...,9,0. tc high while q==9. wrap pulses for 1 cycle after 9->0.
//   2. en=1, up_dn=0 from q=0 -> q=9,8,...; tc high at q==0. wrap pulses after 0->9.
//   3. load=1, load_val=13 -> q=9. load_val=4 with en=1 on the same edge -> q=4 (load wins).
//      clear=1 with load=1 -> q=0 (clear wins).
//   4. en=0 for 5 cycles at q=6, toggling up_dn -> q stays 6; tc=0; wrap=0.
//   5. SATURATE_EN build: count up from 8 -> 9,9,9; wrap never 1; tc=1 while held.
//      Count down from 1 -> 0,0.
//   6. WIDTH=2, MODULUS=4, RESET_VAL=2 -> after reset q=2, then 3,0,1,2. wrap pulses after 3->0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with clear, load, terminal count and wrap pulse.
// Define SATURATE_EN to make the counter stop at its limits instead of wrapping.
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be >= 1");
    end
    if (MODULUS < 2) begin : g_bad_mod_low
        $error("param_updown_counter: MODULUS must be >= 2");
    end
    if (longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod_high
        $error("param_updown_counter: MODULUS must be <= 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
        $error("param_updown_counter: RESET_VAL must be < MODULUS");
    end

    // Count is held one bit wider so MODULUS==2**WIDTH is compared, never overflowed.
    localparam logic [WIDTH:0] MaxCnt = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ModCnt = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] RstCnt = (WIDTH+1)'(RESET_VAL);
    localparam logic [WIDTH:0] One    = (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_q, cnt_d;
    logic [WIDTH:0] load_ext;
    logic           at_max, at_zero;
    logic           wrap_q, wrap_d;

    assign load_ext = {1'b0, load_val};
    assign at_max   = (cnt_q == MaxCnt);
    assign at_zero  = (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_ext >= ModCnt) ? MaxCnt : load_ext;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
`ifdef SATURATE_EN
                    cnt_d  = MaxCnt;
`else
                    cnt_d  = '0;
                    wrap_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + One;
                end
            end else begin
                if (at_zero) begin
`ifdef SATURATE_EN
                    cnt_d  = '0;
`else
                    cnt_d  = MaxCnt;
                    wrap_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= RstCnt;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = cnt_q[WIDTH-1:0];
    assign tc   = en & (up_dn ? at_max : at_zero);
    assign wrap = wrap_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter: directed table, corner sequences and
// random stimulus against an arithmetic reference model; a second small instance covers MODULUS=2**WIDTH.
module tb_param_updown_counter;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int W2 = 2;
    localparam int M2 = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0, up_dn = 1'b0, clear = 1'b0, load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  q;
    logic          tc, wrap;

    logic          en2 = 1'b0;
    logic [W2-1:0] q2;
    logic          tc2, wrap2;

    param_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    param_updown_counter #(.WIDTH(W2), .MODULUS(M2), .RESET_VAL(2)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .up_dn(1'b1), .clear(1'b0), .load(1'b0),
        .load_val(2'b00), .q(q2), .tc(tc2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mq  = 0;
    bit mw  = 1'b0;
    int mq2 = 2;
    bit mw2 = 1'b0;

    typedef struct {
        bit en, up, clr, ld;
        int lv;
        int exp_q;
        bit exp_wrap, exp_tc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: modular arithmetic on integers, or clamping in the saturating build.
    function automatic void model(input int mod, input int cur, input bit e, input bit u,
                                  input bit c, input bit l, input int lv,
                                  output int nq, output bit nw);
        nq = cur;
        nw = 1'b0;
        if (c) nq = 0;
        else if (l) nq = (lv < mod) ? lv : mod - 1;
        else if (e) begin
`ifdef SATURATE_EN
            nq = u ? ((cur + 1 < mod) ? cur + 1 : mod - 1) : ((cur > 0) ? cur - 1 : 0);
`else
            nq = u ? (cur + 1) % mod : (cur + mod - 1) % mod;
            nw = u ? (nq < cur) : (nq > cur);
`endif
        end
    endfunction

    // Inputs change after posedge; DUT updates on negedge; outputs sampled 1 time unit later.
    task automatic step(input bit e, input bit u, input bit c, input bit l, input int lv,
                        input string name);
        int nq;
        bit nw;
        @(posedge clk);
        #1;
        en = e; up_dn = u; clear = c; load = l; load_val = W'(lv);
        model(M, mq, e, u, c, l, lv, nq, nw);
        mq = nq;
        mw = nw;
        @(negedge clk);
        #1;
        check({name, ".q"}, int'(q), mq);
        check({name, ".wrap"}, int'(wrap), int'(mw));
        check({name, ".tc"}, int'(tc), int'(e && (u ? (mq == M - 1) : (mq == 0))));
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{en:0, up:0, clr:0, ld:1, lv:13, exp_q:9, exp_wrap:0, exp_tc:0};
        vecs[1]  = '{en:1, up:1, clr:0, ld:1, lv:4,  exp_q:4, exp_wrap:0, exp_tc:0};
        vecs[2]  = '{en:1, up:0, clr:1, ld:1, lv:7,  exp_q:0, exp_wrap:0, exp_tc:1};
        vecs[3]  = '{en:0, up:0, clr:0, ld:1, lv:6,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[4]  = '{en:0, up:1, clr:0, ld:0, lv:0,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[5]  = '{en:0, up:0, clr:0, ld:0, lv:0,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[6]  = '{en:0, up:1, clr:0, ld:0, lv:0,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[7]  = '{en:0, up:0, clr:0, ld:0, lv:0,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[8]  = '{en:0, up:1, clr:0, ld:0, lv:0,  exp_q:6, exp_wrap:0, exp_tc:0};
        vecs[9]  = '{en:1, up:1, clr:0, ld:0, lv:0,  exp_q:7, exp_wrap:0, exp_tc:0};
        vecs[10] = '{en:0, up:0, clr:0, ld:1, lv:10, exp_q:9, exp_wrap:0, exp_tc:0};
        vecs[11] = '{en:1, up:0, clr:0, ld:1, lv:0,  exp_q:0, exp_wrap:0, exp_tc:1};

        // Reset state
        #12;
        check("reset.q", int'(q), 0);
        check("reset.wrap", int'(wrap), 0);
        check("reset.q2", int'(q2), 2);
        @(posedge clk);
        #1 reset = 1'b1;

        // Count to 7, then asynchronous reset between edges
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, "up_to7");
        #3 reset = 1'b0;
        #1;
        check("async_rst.q", int'(q), 0);
        check("async_rst.wrap", int'(wrap), 0);
        mq = 0;
        en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Up through the wrap, then down through the wrap
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0, "up_seq");
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, "down_seq");

        // Directed table
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].ld, vecs[i].lv, "table");
            check($sformatf("table%0d.q", i), int'(q), vecs[i].exp_q);
            check($sformatf("table%0d.wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
            check($sformatf("table%0d.tc", i), int'(tc), int'(vecs[i].exp_tc));
        end

`ifdef SATURATE_EN
        step(0, 0, 0, 1, 8, "sat_load8");
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, "sat_up");
            check("sat_up.q9", int'(q), 9);
            check("sat_up.wrap0", int'(wrap), 0);
            check("sat_up.tc1", int'(tc), 1);
        end
        step(0, 0, 0, 1, 1, "sat_load1");
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 0, "sat_down");
            check("sat_down.q0", int'(q), 0);
            check("sat_down.wrap0", int'(wrap), 0);
        end
`else
        step(0, 0, 0, 1, 9, "wrap_load9");
        step(1, 1, 0, 0, 0, "wrap_up");
        check("wrap_up.q0", int'(q), 0);
        check("wrap_up.pulse", int'(wrap), 1);
        step(1, 0, 0, 0, 0, "wrap_down");
        check("wrap_down.q9", int'(q), 9);
        check("wrap_down.pulse", int'(wrap), 1);
        step(1, 0, 0, 0, 0, "wrap_after");
        check("wrap_after.q8", int'(q), 8);
        check("wrap_after.low", int'(wrap), 0);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)), "rand");
        end

        // Second instance: WIDTH=2, MODULUS=4, RESET_VAL=2
        @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b0; clear = 1'b0; load = 1'b0;
        #2;
        check("inst2.reset_q", int'(q2), 2);
        mq = 0;
        mq2 = 2;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int nq;
            bit nw;
            @(posedge clk);
            #1 en2 = 1'b1;
            model(M2, mq2, 1'b1, 1'b1, 1'b0, 1'b0, 0, nq, nw);
            mq2 = nq;
            mw2 = nw;
            @(negedge clk);
            #1;
            check("inst2.q", int'(q2), mq2);
            check("inst2.wrap", int'(wrap2), int'(mw2));
            check("inst2.tc", int'(tc2), int'(mq2 == M2 - 1));
`ifndef SATURATE_EN
            if (i == 1) check("inst2.wrap_after_3to0", int'(wrap2), 1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
